// File: rtl/io_seq_monitor_pkg.sv
// Shared types for the mprj_io result-sequence monitor: FSM states and fail codes.
package io_seq_monitor_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        RUN,
        PASS,
        FAIL
    } state_t;

    localparam logic [1:0] FC_NONE = 2'd0;
    localparam logic [1:0] FC_TMO  = 2'd1;
    localparam logic [1:0] FC_CFG  = 2'd2;

endpackage

// File: rtl/io_seq_table.sv
// Expected-word table: {mask, data} per entry, one write port, one async read port.
module io_seq_table #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16
) (
    input  logic                     clock,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [DATA_W-1:0]        wmask,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_W-1:0]        rdata,
    output logic [DATA_W-1:0]        rmask
);

    logic [2*DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= {wmask, wdata};
        end
    end

    assign {rmask, rdata} = mem[raddr];

endmodule

// File: rtl/io_seq_monitor.sv
// Checks that obs_data walks through a programmed table of masked words in order,
// each held stable for STABLE_CYC cycles and arriving within a per-entry timeout.
module io_seq_monitor
    import io_seq_monitor_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int DEPTH      = 16,
    parameter int STABLE_CYC = 2,
    parameter int TMO_W      = 20
) (
    input  logic                     clock,
    input  logic                     resetb,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [DATA_W-1:0]        wr_mask,
    output logic                     wr_err,
    input  logic [$clog2(DEPTH):0]   num_entries,
    input  logic [TMO_W-1:0]         tmo_limit,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     obs_ready,
    input  logic [DATA_W-1:0]        obs_data,
    output logic                     busy,
    output logic                     pass,
    output logic                     fail,
    output logic [1:0]               fail_code,
    output logic [$clog2(DEPTH):0]   cur_idx,
    output logic [31:0]              cyc_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int IW = AW + 1;
    localparam int SW = $clog2(STABLE_CYC + 1);
    localparam logic [IW-1:0] DEPTH_I  = IW'(DEPTH);
    localparam logic [SW-1:0] STAB_TOP = SW'(STABLE_CYC - 1);

    state_t            state;
    logic [IW-1:0]     num_r;
    logic [TMO_W-1:0]  tmo_lim_r;
    logic [TMO_W-1:0]  tmo_cnt;
    logic [TMO_W-1:0]  tmo_nxt;
    logic [SW-1:0]     stab_cnt;
    logic              match_p1;
    logic              vld_p1;
    logic [DATA_W-1:0] exp_data;
    logic [DATA_W-1:0] exp_mask;
    logic              busy_st;
    logic              wr_ok;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

    function automatic logic [TMO_W-1:0] sat_inc_tmo(input logic [TMO_W-1:0] v);
        return (&v) ? v : v + TMO_W'(1);
    endfunction

    assign busy_st = (state == ARMED) || (state == RUN);
    assign wr_ok   = wr_en && !busy_st;
    assign tmo_nxt = sat_inc_tmo(tmo_cnt);

    io_seq_table #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_table (
        .clock (clock),
        .we    (wr_ok),
        .waddr (wr_addr),
        .wdata (wr_data),
        .wmask (wr_mask),
        .raddr (cur_idx[AW-1:0]),
        .rdata (exp_data),
        .rmask (exp_mask)
    );

    // p1: registered masked compare against the entry currently addressed
    always_ff @(posedge clock) begin
        match_p1 <= ((obs_data ^ exp_data) & exp_mask) == '0;
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state     <= IDLE;
            busy      <= 1'b0;
            pass      <= 1'b0;
            fail      <= 1'b0;
            fail_code <= FC_NONE;
            cur_idx   <= '0;
            cyc_count <= '0;
            wr_err    <= 1'b0;
            num_r     <= '0;
            tmo_lim_r <= '0;
            tmo_cnt   <= '0;
            stab_cnt  <= '0;
            vld_p1    <= 1'b0;
        end else begin
            wr_err <= wr_en && busy_st;
            // A compare is only trusted if it was taken in RUN against the same entry
            vld_p1 <= 1'b0;
            if (abort) begin
                state     <= IDLE;
                busy      <= 1'b0;
                pass      <= 1'b0;
                fail      <= 1'b0;
                fail_code <= FC_NONE;
                cur_idx   <= '0;
                cyc_count <= '0;
                stab_cnt  <= '0;
                tmo_cnt   <= '0;
            end else begin
                case (state)
                    IDLE, PASS, FAIL: begin
                        if (start) begin
                            pass      <= 1'b0;
                            fail      <= 1'b0;
                            fail_code <= FC_NONE;
                            cur_idx   <= '0;
                            cyc_count <= '0;
                            stab_cnt  <= '0;
                            tmo_cnt   <= '0;
                            num_r     <= num_entries;
                            tmo_lim_r <= tmo_limit;
                            if (num_entries > DEPTH_I) begin
                                state     <= FAIL;
                                fail      <= 1'b1;
                                fail_code <= FC_CFG;
                            end else begin
                                state <= ARMED;
                                busy  <= 1'b1;
                            end
                        end
                    end
                    ARMED: begin
                        if (obs_ready) begin
                            if (num_r == '0) begin
                                state <= PASS;
                                busy  <= 1'b0;
                                pass  <= 1'b1;
                            end else begin
                                state <= RUN;
                            end
                        end
                    end
                    RUN: begin
                        cyc_count <= sat_inc32(cyc_count);
                        if (cur_idx == num_r) begin
                            state <= PASS;
                            busy  <= 1'b0;
                            pass  <= 1'b1;
                        end else if (vld_p1 && match_p1 && stab_cnt == STAB_TOP) begin
                            cur_idx  <= cur_idx + IW'(1);
                            stab_cnt <= '0;
                            tmo_cnt  <= '0;
                        end else begin
                            vld_p1   <= 1'b1;
                            stab_cnt <= (vld_p1 && match_p1) ? stab_cnt + SW'(1) : '0;
                            if (tmo_lim_r != '0 && tmo_nxt == tmo_lim_r) begin
                                state     <= FAIL;
                                busy      <= 1'b0;
                                fail      <= 1'b1;
                                fail_code <= FC_TMO;
                            end else begin
                                tmo_cnt <= tmo_nxt;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_io_seq_monitor.sv
// Directed bench for io_seq_monitor: ordered sequence, timeout, masking, config errors,
// abort, busy writes and asynchronous reset.
module tb_io_seq_monitor;

    logic        clock = 1'b0;
    logic        resetb = 1'b0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic [15:0] wr_mask = '0;
    logic        wr_err;
    logic [4:0]  num_entries = '0;
    logic [19:0] tmo_limit = '0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        obs_ready = 1'b0;
    logic [15:0] obs_data = '0;
    logic        busy;
    logic        pass;
    logic        fail;
    logic [1:0]  fail_code;
    logic [4:0]  cur_idx;
    logic [31:0] cyc_count;

    int n_checks = 0;
    int n_errors = 0;
    logic [15:0] seq [8];

    io_seq_monitor #(
        .DATA_W     (16),
        .DEPTH      (16),
        .STABLE_CYC (2),
        .TMO_W      (20)
    ) dut (
        .clock       (clock),
        .resetb      (resetb),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_mask     (wr_mask),
        .wr_err      (wr_err),
        .num_entries (num_entries),
        .tmo_limit   (tmo_limit),
        .start       (start),
        .abort       (abort),
        .obs_ready   (obs_ready),
        .obs_data    (obs_data),
        .busy        (busy),
        .pass        (pass),
        .fail        (fail),
        .fail_code   (fail_code),
        .cur_idx     (cur_idx),
        .cyc_count   (cyc_count)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic write_entry(input logic [3:0] a, input logic [15:0] d, input logic [15:0] m);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        wr_mask = m;
        tick(1);
        wr_en = 1'b0;
    endtask

    task automatic start_run(input logic [4:0] n, input logic [19:0] t);
        num_entries = n;
        tmo_limit   = t;
        start       = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic drive(input logic [15:0] v, input int n);
        obs_data = v;
        tick(n);
    endtask

    // Full 8-entry sequence with 3-cycle holds, starting from a non-busy state
    task automatic run_full_seq();
        obs_ready = 1'b0;
        start_run(5'd8, 20'd1000);
        obs_ready = 1'b1;
        for (int i = 0; i < 8; i++) drive(seq[i], 3);
        tick(3);
    endtask

    initial begin
        seq = '{16'h5D44, 16'h2D29, 16'h63ED, 16'h7508, 16'h79BA, 16'h4DA1, 16'h5C80, 16'h0000};

        tick(3);
        check_val("rst_busy", busy, 0);
        check_val("rst_pass", pass, 0);
        check_val("rst_fail", fail, 0);
        check_val("rst_idx", cur_idx, 0);
        check_val("rst_cyc", cyc_count, 0);
        resetb = 1'b1;
        tick(1);

        // 1: ordered sequence
        for (int i = 0; i < 8; i++) write_entry(4'(i), seq[i], 16'hFFFF);
        run_full_seq();
        check_val("t1_pass", pass, 1);
        check_val("t1_fail", fail, 0);
        check_val("t1_idx", cur_idx, 8);
        check_val("t1_busy", busy, 0);
        check_val("t1_cyc", cyc_count, 25);

        // 2: third entry skipped -> timeout exactly 1000 cycles after second accept
        obs_ready = 1'b0;
        start_run(5'd8, 20'd1000);
        check_val("t2_pass_clr", pass, 0);
        obs_ready = 1'b1;
        drive(seq[0], 3);
        drive(seq[1], 3);
        drive(seq[3], 1);
        check_val("t2_idx_acc", cur_idx, 2);
        tick(999);
        check_val("t2_fail_early", fail, 0);
        check_val("t2_busy_early", busy, 1);
        tick(1);
        check_val("t2_fail", fail, 1);
        check_val("t2_code", fail_code, 1);
        check_val("t2_idx", cur_idx, 2);

        // 3: masked entry and single-cycle glitch
        obs_ready = 1'b0;
        write_entry(4'd0, 16'h0044, 16'h00FF);
        write_entry(4'd1, 16'h5D44, 16'hFFFF);
        start_run(5'd2, 20'd0);
        obs_ready = 1'b1;
        drive(16'hA144, 3);
        drive(16'h0000, 1);
        check_val("t3_mask_acc", cur_idx, 1);
        drive(16'h5D44, 1);
        drive(16'h0000, 5);
        check_val("t3_glitch_idx", cur_idx, 1);
        check_val("t3_glitch_busy", busy, 1);
        check_val("t3_no_tmo", fail, 0);
        drive(16'h5D44, 5);
        check_val("t3_pass", pass, 1);
        check_val("t3_idx", cur_idx, 2);

        // 4: bad config and empty sequence
        obs_ready = 1'b0;
        start_run(5'd17, 20'd0);
        check_val("t4_cfg_fail", fail, 1);
        check_val("t4_cfg_code", fail_code, 2);
        check_val("t4_cfg_busy", busy, 0);
        check_val("t4_cfg_pass", pass, 0);
        start_run(5'd0, 20'd0);
        check_val("t4_arm_busy", busy, 1);
        check_val("t4_arm_code", fail_code, 0);
        tick(3);
        check_val("t4_arm_wait", pass, 0);
        obs_ready = 1'b1;
        tick(1);
        check_val("t4_empty_pass", pass, 1);
        check_val("t4_empty_idx", cur_idx, 0);
        check_val("t4_empty_busy", busy, 0);

        // 5: abort mid-run, rejected write, abort beats start
        obs_ready = 1'b0;
        write_entry(4'd0, seq[0], 16'hFFFF);
        write_entry(4'd1, seq[1], 16'hFFFF);
        start_run(5'd8, 20'd1000);
        obs_ready = 1'b1;
        for (int i = 0; i < 3; i++) drive(seq[i], 3);
        drive(seq[3], 1);
        check_val("t5_idx3", cur_idx, 3);
        wr_en   = 1'b1;
        wr_addr = 4'd0;
        wr_data = 16'hFFFF;
        wr_mask = 16'hFFFF;
        tick(1);
        wr_en = 1'b0;
        check_val("t5_wr_err", wr_err, 1);
        tick(1);
        check_val("t5_wr_err_pulse", wr_err, 0);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        check_val("t5_abort_busy", busy, 0);
        check_val("t5_abort_idx", cur_idx, 0);
        check_val("t5_abort_pass", pass, 0);
        check_val("t5_abort_fail", fail, 0);
        check_val("t5_abort_cyc", cyc_count, 0);
        abort       = 1'b1;
        start       = 1'b1;
        num_entries = 5'd8;
        tick(1);
        abort = 1'b0;
        start = 1'b0;
        check_val("t5_abort_wins", busy, 0);
        run_full_seq();
        check_val("t5_table_kept", pass, 1);
        check_val("t5_table_idx", cur_idx, 8);

        // 6: asynchronous reset mid-run, then a clean run
        obs_ready = 1'b0;
        start_run(5'd8, 20'd1000);
        obs_ready = 1'b1;
        drive(seq[0], 3);
        drive(seq[1], 3);
        check_val("t6_pre_idx", cur_idx, 1);
        #2 resetb = 1'b0;
        #1;
        check_val("t6_rst_busy", busy, 0);
        check_val("t6_rst_idx", cur_idx, 0);
        check_val("t6_rst_cyc", cyc_count, 0);
        check_val("t6_rst_flags", {29'd0, pass, fail, wr_err}, 0);
        check_val("t6_rst_code", fail_code, 0);
        tick(2);
        resetb = 1'b1;
        tick(1);
        run_full_seq();
        check_val("t6_pass", pass, 1);
        check_val("t6_idx", cur_idx, 8);
        check_val("t6_cyc", cyc_count, 25);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
